mul_arbiter: RTL and testbench

Round-robin arbiter that shares one sequential 8x8 multiplier (`mul`) between N requesters. It accepts operand pairs over a per-requester req/ack handshake and issues them to the multiplier one at a time. It tracks the multiplier's start/busy protocol, returns each 16-bit product to its owner with a one-cycle done pulse, and flags a hung multiplier with a watchdog. It sits between the requesting datapath units and the single `mul` instance.

---
 rtl/mul_arbiter.sv | 107 ++++++++++
 tb/tb_mul_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one sequential multiplier among N requesters,
// with a start/busy watchdog that returns an error result on a hung multiplier.
module mul_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int START_TO = 4,
  parameter int DONE_TO  = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] a_bi,
  input  logic [N*W-1:0] b_bi,
  output logic [N-1:0]   ack_o,
  output logic [N-1:0]   done_o,
  output logic [2*W-1:0] y_bo,
  output logic           err_o,
  output logic           busy_o,
  output logic           mul_start_o,
  output logic [W-1:0]   mul_a_bo,
  output logic [W-1:0]   mul_b_bo,
  input  logic           mul_busy_i,
  input  logic [2*W-1:0] mul_y_bi
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(((DONE_TO > START_TO) ? DONE_TO : START_TO) + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;
  logic [2:0]    state;
  logic [IW-1:0] ptr, owner, gnt;
  logic          found;
  logic [CW-1:0] cnt;
  // scan downward so the requester closest at/after ptr wins
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        gnt   = IW'((int'(ptr) + i) % N);
      end
    end
  end
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      ack_o       <= '0;
      done_o      <= '0;
      y_bo        <= '0;
      err_o       <= 1'b0;
      mul_start_o <= 1'b0;
      mul_a_bo    <= '0;
      mul_b_bo    <= '0;
    end else begin
      ack_o       <= '0;
      done_o      <= '0;
      mul_start_o <= 1'b0;
      case (state)
        IDLE: if (found) begin
          ack_o       <= N'(1) << gnt;
          mul_a_bo    <= a_bi[int'(gnt)*W +: W];
          mul_b_bo    <= b_bi[int'(gnt)*W +: W];
          owner       <= gnt;
          ptr         <= (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
          mul_start_o <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (mul_busy_i) begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end else if (cnt == CW'(START_TO - 1)) begin
          y_bo   <= '0;
          err_o  <= 1'b1;
          done_o <= N'(1) << owner;
          state  <= RESP;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!mul_busy_i) begin
          y_bo   <= mul_y_bi;
          err_o  <= 1'b0;
          done_o <= N'(1) << owner;
          state  <= RESP;
        end else if (cnt == CW'(DONE_TO - 1)) begin
          y_bo   <= '0;
          err_o  <= 1'b1;
          done_o <= N'(1) << owner;
          state  <= RESP;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vector table plus reset-abort sequence against a 3-cycle multiplier model.
module tb_mul_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] a_bi = '0, b_bi = '0;
  logic [3:0]  ack_o, done_o;
  logic [15:0] y_bo, mul_y_bi;
  logic        err_o, busy_o, mul_start_o, mul_busy_i;
  logic [7:0]  mul_a_bo, mul_b_bo;
  int checks = 0, errors = 0, mode = 0;
  logic [1:0]  busy_cnt;
  mul_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_bi(a_bi), .b_bi(b_bi),
    .ack_o(ack_o), .done_o(done_o), .y_bo(y_bo), .err_o(err_o), .busy_o(busy_o),
    .mul_start_o(mul_start_o), .mul_a_bo(mul_a_bo), .mul_b_bo(mul_b_bo),
    .mul_busy_i(mul_busy_i), .mul_y_bi(mul_y_bi)
  );
  always #5 clk_i = ~clk_i;
  // mode 0: busy for 3 cycles after start; 1: busy stuck low; 2: busy stuck high
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_cnt <= '0;
      mul_y_bi <= '0;
    end else if (mul_start_o) begin
      busy_cnt <= 2'd3;
      mul_y_bi <= mul_a_bo * mul_b_bo;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1'b1;
  end
  assign mul_busy_i = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (busy_cnt != 0);
  typedef struct {
    logic [3:0]  req;
    logic [31:0] a, b;
    int          mode;
    logic [3:0]  gnt;
    logic [7:0]  ma;
    logic [15:0] y;
    logic        err;
    int          gap;
  } vec_t;
  vec_t vecs[17];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_txn(input vec_t v);
    int g;
    bit got, stray;
    mode = v.mode;
    req_i = v.req;
    a_bi = v.a;
    b_bi = v.b;
    got = 0;
    stray = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (done_o != 0) stray = 1;
      if (ack_o != 0) got = 1;
    end
    check("stray_done", 32'(stray), 0);
    check("ack", 32'(ack_o), 32'(v.gnt));
    check("start", 32'(mul_start_o), 1);
    check("mul_a", 32'(mul_a_bo), 32'(v.ma));
    check("busy", 32'(busy_o), 1);
    req_i = '0;
    got = 0;
    g = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      g++;
      if (i == 0) check("ack_pulse", 32'({ack_o, mul_start_o}), 0);
      if (done_o != 0) got = 1;
    end
    check("done", 32'(done_o), 32'(v.gnt));
    check("y", 32'(y_bo), 32'(v.y));
    check("err", 32'(err_o), 32'(v.err));
    check("gap", 32'(g), 32'(v.gap));
    @(negedge clk_i);
    check("after_resp", 32'({done_o, err_o}), 0);
  endtask
  initial begin
    vecs[0]  = '{4'b1111, 32'h05040302, 32'h05040302, 0, 4'b0001, 8'd2, 16'd4, 1'b0, 5};
    vecs[1]  = '{4'b1111, 32'h05040302, 32'h05040302, 0, 4'b0010, 8'd3, 16'd9, 1'b0, 5};
    vecs[2]  = '{4'b1111, 32'h05040302, 32'h05040302, 0, 4'b0100, 8'd4, 16'd16, 1'b0, 5};
    vecs[3]  = '{4'b1111, 32'h05040302, 32'h05040302, 0, 4'b1000, 8'd5, 16'd25, 1'b0, 5};
    for (int i = 0; i < 6; i++)
      vecs[4+i] = (i % 2 == 0) ? '{4'b0101, 32'h000B0007, 32'h000D0009, 0, 4'b0001, 8'd7, 16'd63, 1'b0, 5}
                               : '{4'b0101, 32'h000B0007, 32'h000D0009, 0, 4'b0100, 8'd11, 16'd143, 1'b0, 5};
    vecs[10] = '{4'b1000, 32'h09000000, 32'h09000000, 1, 4'b1000, 8'd9, 16'd0, 1'b1, 5};
    vecs[11] = '{4'b0001, 32'h00000009, 32'h00000009, 2, 4'b0001, 8'd9, 16'd0, 1'b1, 66};
    vecs[12] = '{4'b0001, 32'h00000003, 32'h00000005, 0, 4'b0001, 8'd3, 16'd15, 1'b0, 5};
    vecs[13] = '{4'b0100, 32'h00000000, 32'h00C80000, 0, 4'b0100, 8'd0, 16'd0, 1'b0, 5};
    vecs[14] = '{4'b0010, 32'h0000FF00, 32'h0000FF00, 0, 4'b0010, 8'd255, 16'd65025, 1'b0, 5};
    vecs[15] = '{4'b1001, 32'h0600000A, 32'h0700000A, 0, 4'b0001, 8'd10, 16'd100, 1'b0, 5};
    vecs[16] = '{4'b1000, 32'h0600000A, 32'h0700000A, 0, 4'b1000, 8'd6, 16'd42, 1'b0, 5};
    repeat (2) @(negedge clk_i);
    check("rst_outs", 32'({ack_o, done_o, err_o, busy_o, mul_start_o}), 0);
    check("rst_y", 32'(y_bo), 0);
    check("rst_ops", 32'({mul_a_bo, mul_b_bo}), 0);
    rst_i = 1'b1;
    for (int i = 0; i < 15; i++) run_txn(vecs[i]);
    mode = 2;
    req_i = 4'b0010;
    a_bi = 32'h00003300;
    b_bi = 32'h00004400;
    for (int i = 0; i < 20 && ack_o == 0; i++) @(negedge clk_i);
    check("abort_ack", 32'(ack_o), 32'b0010);
    req_i = '0;
    repeat (4) @(negedge clk_i);
    check("abort_busy", 32'(busy_o), 1);
    #2 rst_i = 1'b0;
    #1;
    check("async_outs", 32'({ack_o, done_o, err_o, busy_o, mul_start_o}), 0);
    check("async_y", 32'(y_bo), 0);
    check("async_ops", 32'({mul_a_bo, mul_b_bo}), 0);
    mode = 0;
    repeat (2) @(negedge clk_i);
    check("held_rst", 32'({done_o, busy_o}), 0);
    rst_i = 1'b1;
    run_txn(vecs[15]);
    run_txn(vecs[16]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
